// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver.
//   master : whoever owns the display registers (drives en/load/data, sees pins)
//   slave  : the scan driver itself
// Signals:
//   en          scan enable
//   load        one-cycle strobe, capture data_in/dp_in/blank_mask into staging
//   data_in     packed nibbles, digit i = data_in[4i+3:4i]
//   dp_in       decimal point request per digit (1 = lit)
//   blank_mask  per-digit full blank, dp included (1 = dark)
//   lz_blank    leading-zero blanking enable
//   seg         active-low segments, seg[7]=a .. seg[1]=g, seg[0]=dp
//   an          active-low one-hot digit select
//   frame_done  one-cycle pulse after each frame wrap
interface seg_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lz_blank;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output en, load, data_in, dp_in, blank_mask, lz_blank,
    input  seg, an, frame_done
  );

  modport slave (
    input  en, load, data_in, dp_in, blank_mask, lz_blank,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  seg_scan_driver_if.slave (inputs en/load/data_in/dp_in/blank_mask/
//        lz_blank; registered outputs seg/an/frame_done)
// Each digit owns DIV clocks; the first clock of every slot is a dark guard
// cycle so the previous digit's segments never ghost onto the next anode.
// New display contents are staged and only copied into the shadow set at a
// frame wrap, so a frame is never drawn with a mix of old and new data.
module seg_scan_driver #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_driver_if.slave bus
);

  localparam int CW = (DIV    > 1) ? $clog2(DIV)    : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } frame_t;

  frame_t          live, staging, shadow;
  logic            pending;
  logic [CW-1:0]   div_cnt;
  logic [IW-1:0]   idx;
  logic [7:0]      seg_q;
  logic [DIGITS-1:0] an_q;
  logic            frame_done_q;

  logic            tick, wrap;
  logic [3:0]      cur_nib;
  logic            cur_dp, cur_blank, cur_lz;
  logic [7:0]      cur_seg;

  assign live.data  = bus.data_in;
  assign live.dp    = bus.dp_in;
  assign live.blank = bus.blank_mask;

  assign tick = bus.en && (div_cnt == DIV_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // Glyph with dp bit held dark; caller supplies the real dp bit.
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    unique case (nib)
      4'h0: glyph = 8'h03;  4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;  4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;  4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;  4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;  4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;  4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;  4'hF: glyph = 8'h71;
    endcase
  endfunction

  // Select the current digit and decide whether it sits inside the run of
  // zero nibbles that starts at the most significant digit.
  always_comb begin
    logic zero_above;
    logic [7:0] g;
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would otherwise infer a latch.
    zero_above = 1'b1;
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_lz     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (shadow.data[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        cur_nib   = shadow.data[4*i +: 4];
        cur_dp    = shadow.dp[i];
        cur_blank = shadow.blank[i];
        cur_lz    = zero_above;
      end
    end

    g = glyph(cur_nib);
    if (cur_blank)
      cur_seg = 8'hFF;
    else if (bus.lz_blank && (idx != '0) && cur_lz)
      cur_seg = {7'h7F, ~cur_dp};
    else
      cur_seg = {g[7:1], ~cur_dp};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: staging and shadow are reset too: a reset must drop any
      // queued display update, not just the scan position.
      div_cnt      <= '0;
      idx          <= '0;
      staging      <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // below sees the pre-edge value regardless of statement order.
      frame_done_q <= wrap;

      if (bus.en) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick)
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (bus.load)
        staging <= live;

      // A load landing on the wrap bypasses staging entirely.
      if (wrap && bus.load) begin
        shadow  <= live;
        pending <= 1'b0;
      end else if (wrap && pending) begin
        shadow  <= staging;
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      if (!bus.en || (div_cnt == '0)) begin
        seg_q <= 8'hFF;
        an_q  <= '1;
      end else begin
        seg_q <= cur_seg;
        an_q  <= ~(DIGITS'(1) << idx);
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  localparam logic [7:0] GLYPH [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: scan position is simply the number of enabled clocks
  // since reset, modulo one frame.
  int unsigned       k;
  logic [15:0]       m_sh_data, m_st_data;
  logic [3:0]        m_sh_dp, m_sh_bl, m_st_dp, m_st_bl;
  bit                m_pend;
  logic [7:0]        exp_seg;
  logic [3:0]        exp_an;
  logic              exp_fd;
  logic [7:0]        cap [DIGITS];

  task automatic model_reset();
    k = 0;
    m_sh_data = '0; m_sh_dp = '0; m_sh_bl = '0;
    m_st_data = '0; m_st_dp = '0; m_st_bl = '0;
    m_pend = 0;
  endtask

  function automatic logic [7:0] digit_seg(int i);
    logic [7:0] g;
    g = GLYPH[(m_sh_data >> (4*i)) & 16'hF];
    if (m_sh_bl[i])
      return 8'hFF;
    if (bus.lz_blank && i != 0 && (m_sh_data >> (4*i)) == 0)
      return {7'h7F, ~m_sh_dp[i]};
    return {g[7:1], ~m_sh_dp[i]};
  endfunction

  // Predict what the outputs show after the next edge, advance model and DUT
  // by one clock, and leave the bench parked on the falling edge.
  task automatic cycle();
    int slot, d;
    bit wrap;
    slot = k % DIV;
    d    = (k / DIV) % DIGITS;
    if (!bus.en || slot == 0) begin
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
    end else begin
      exp_seg = digit_seg(d);
      exp_an  = ~(4'b1 << d);
    end
    wrap   = bus.en && slot == DIV - 1 && d == DIGITS - 1;
    exp_fd = wrap;
    if (wrap && bus.load) begin
      m_sh_data = bus.data_in; m_sh_dp = bus.dp_in; m_sh_bl = bus.blank_mask;
      m_pend = 0;
    end else if (wrap && m_pend) begin
      m_sh_data = m_st_data; m_sh_dp = m_st_dp; m_sh_bl = m_st_bl;
      m_pend = 0;
    end else if (bus.load) begin
      m_pend = 1;
    end
    if (bus.load) begin
      m_st_data = bus.data_in; m_st_dp = bus.dp_in; m_st_bl = bus.blank_mask;
    end
    if (bus.en) k = (k + 1) % FRAME;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic clear_cap();
    for (int i = 0; i < DIGITS; i++) cap[i] = 8'hXX;
  endtask

  task automatic grab();
    for (int i = 0; i < DIGITS; i++)
      if (bus.an === ~(4'b1 << i)) cap[i] = bus.seg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0;
    bus.blank_mask = '0; bus.lz_blank = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.seg !== 8'hFF) begin
      n_fail++; $display("FAIL reset_seg: got %h want ff", bus.seg);
    end
    n_checks++;
    if (bus.an !== 4'hF) begin
      n_fail++; $display("FAIL reset_an: got %b want 1111", bus.an);
    end
    n_checks++;
    if (bus.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_fd: got %b want 0", bus.frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int fd_cnt = 0;
    int act [DIGITS];
    for (int i = 0; i < DIGITS; i++) act[i] = 0;
    repeat (2 * FRAME) begin
      cycle();
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL scan: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
      fd_cnt += int'(bus.frame_done);
      for (int i = 0; i < DIGITS; i++)
        if (bus.an === ~(4'b1 << i) && bus.seg === 8'h03) act[i]++;
    end
    n_checks++;
    if (fd_cnt != 2) begin
      n_fail++; $display("FAIL scan_frame_done: got %0d pulses want 2", fd_cnt);
    end
    for (int i = 0; i < DIGITS; i++) begin
      n_checks++;
      if (act[i] != 2 * (DIV - 1)) begin
        n_fail++;
        $display("FAIL scan_slot%0d: active %0d cycles want %0d", i, act[i], 2 * (DIV - 1));
      end
    end
  endtask

  // Loads mid-frame, lets the frame wrap, then captures one full frame.
  task automatic load_and_show(string name, logic [15:0] data, logic [3:0] dp,
                               logic [3:0] bl, logic lz);
    int guard = 0;
    repeat (5) cycle();
    bus.data_in = data; bus.dp_in = dp; bus.blank_mask = bl; bus.lz_blank = lz;
    bus.load = 1'b1;
    clear_cap();
    do begin
      cycle();
      guard++;
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL %s_pre: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 name, bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
    end while (k != 0 && guard < 4 * FRAME);
    repeat (FRAME) begin
      cycle();
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL %s: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 name, bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
      grab();
    end
  endtask

  task automatic check_caps(string name, logic [7:0] w3, logic [7:0] w2,
                            logic [7:0] w1, logic [7:0] w0);
    logic [7:0] want [DIGITS];
    want[0] = w0; want[1] = w1; want[2] = w2; want[3] = w3;
    for (int i = 0; i < DIGITS; i++) begin
      n_checks++;
      if (cap[i] !== want[i]) begin
        n_fail++; $display("FAIL %s_digit%0d: got %h want %h", name, i, cap[i], want[i]);
      end
    end
  endtask

  task automatic test_load_frame();
    load_and_show("load_frame", 16'h1A3F, 4'b0010, 4'b0000, 1'b0);
    check_caps("load_frame", 8'h9F, 8'h11, 8'h0C, 8'h71);
  endtask

  task automatic test_leading_zero();
    load_and_show("lz", 16'h0050, 4'b0000, 4'b0000, 1'b1);
    check_caps("lz", 8'hFF, 8'hFF, 8'h49, 8'h03);
    load_and_show("lz_dp", 16'h0050, 4'b1000, 4'b0000, 1'b1);
    check_caps("lz_dp", 8'hFE, 8'hFF, 8'h49, 8'h03);
  endtask

  task automatic test_blank();
    load_and_show("blank", 16'h4321, 4'b0100, 4'b0100, 1'b0);
    check_caps("blank", 8'h99, 8'hFF, 8'h25, 8'h9F);
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    while (k != FRAME - 1 && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
    n_checks++;
    if (k != FRAME - 1) begin
      n_fail++; $display("FAIL wrap_align: model pos %0d want %0d", k, FRAME - 1);
    end
    bus.data_in = 16'h8888; bus.dp_in = '0; bus.blank_mask = '0; bus.lz_blank = 1'b0;
    bus.load = 1'b1;
    cycle();
    n_checks++;
    if (dut.pending !== 1'b0) begin
      n_fail++; $display("FAIL wrap_load_pending: got %b want 0", dut.pending);
    end
    clear_cap();
    repeat (FRAME) begin
      cycle();
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL wrap_load: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
      grab();
    end
    check_caps("wrap_load", 8'h01, 8'h01, 8'h01, 8'h01);
    repeat (6) cycle();
    bus.en = 1'b0;
    repeat (10) begin
      cycle();
      n_checks++;
      if (bus.seg !== 8'hFF || bus.an !== 4'hF || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled: seg=%h an=%b fd=%b want seg=ff an=1111 fd=0",
                 bus.seg, bus.an, bus.frame_done);
      end
    end
    bus.en = 1'b1;
    repeat (FRAME + 4) begin
      cycle();
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL resume: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    repeat (8 * FRAME) begin
      if ($urandom_range(7) == 0) begin
        bus.data_in = 16'($urandom);
        if ($urandom_range(1) == 1)
          bus.data_in = bus.data_in >> (4 * $urandom_range(3));
        bus.dp_in      = 4'($urandom);
        bus.blank_mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
        bus.lz_blank   = 1'($urandom);
        bus.load       = 1'b1;
      end
      bus.en = ($urandom_range(9) != 0);
      cycle();
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL random: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
    end
    bus.en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bus.lz_blank = 1'b0;
    while (k % DIV != 1 && guard < FRAME) begin
      cycle();
      guard++;
    end
    bus.data_in = 16'hABCD; bus.dp_in = 4'hF; bus.blank_mask = '0;
    bus.load = 1'b1;
    cycle();
    n_checks++;
    if (bus.an === 4'hF) begin
      n_fail++; $display("FAIL reset_mid_pre: an=%b want a digit selected", bus.an);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.seg !== 8'hFF || bus.an !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_mid_async: seg=%h an=%b want seg=ff an=1111", bus.seg, bus.an);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_cap();
    repeat (2 * FRAME) begin
      cycle();
      n_checks++;
      if ({bus.seg, bus.an, bus.frame_done} !== {exp_seg, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL reset_mid: seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 bus.seg, bus.an, bus.frame_done, exp_seg, exp_an, exp_fd);
      end
      grab();
    end
    check_caps("reset_mid", 8'h03, 8'h03, 8'h03, 8'h03);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_frame();
    test_leading_zero();
    test_blank();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
